// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Single-port data-memory responder at the far end of the CPU dmem_* bus.
// It decodes each access, commits writes to an internal word array and
// returns read data on the shared tri-state dmem_data line one cycle later.
// A post-reset sequencer holds off service until the array is in a known
// state.
//
// Optional feature (compile-time macro DMEM_RESPONDER_CLEAR_EN):
//   defined   - after reset the whole array is zero-filled, one word per
//               cycle, before dmem_ready rises (DEPTH+1 cycles after the
//               first posedge with rst low).
//   undefined - no clear pass; dmem_ready rises 1 cycle after the first
//               posedge with rst low and array contents survive rst.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two, at least 4)
//   ADDR_W     word-index width, derived from DEPTH
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   dmem_wen   1 = write, 0 = read; an access is presented every cycle
//   dmem_addr  byte address; word index is dmem_addr[ADDR_W+1:2]
//   dmem_data  write data in; read data driven out the cycle after a read
//   dmem_ready high while accesses are being serviced
//   dmem_err   one-cycle pulse in the cycle after a rejected access
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_wen,
   input  logic [31:0] dmem_addr,
   inout  wire  [31:0] dmem_data,
   output logic        dmem_ready,
   output logic        dmem_err
);

`ifdef DMEM_RESPONDER_CLEAR_EN
   typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_RUN} state_t;
`else
   typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;
`endif

   // One past the highest legal byte address; 33 bits so that even a
   // 2^30-word array cannot overflow the comparison.
   localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;

   state_t             state;
   logic [31:0]        rdata_q;
   logic               drv_q;
   logic [ADDR_W-1:0]  idx;
   logic               addr_ok;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_waddr;
   logic [31:0]        mem_wdata;
   logic [31:0]        mem [DEPTH];

`ifdef DMEM_RESPONDER_CLEAR_EN
   logic [ADDR_W-1:0]  clr_idx;
`endif

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   assign idx     = dmem_addr[ADDR_W+1:2];
   assign addr_ok = (dmem_addr[1:0] == 2'b00) && ({1'b0, dmem_addr} < BYTE_LIMIT);

   // ---------------------------------------------------------------------
   // Array write port: shared by the bus and the clear sequencer. The two
   // never collide because dmem_ready is low throughout CLEAR.
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise paths that skip an assignment infer a latch.
      mem_we    = 1'b0;
      mem_waddr = idx;
      mem_wdata = dmem_data;
      if (!rst) begin
         if (dmem_ready && dmem_wen && addr_ok) begin
            mem_we = 1'b1;
         end
`ifdef DMEM_RESPONDER_CLEAR_EN
         if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx;
            mem_wdata = '0;
         end
`endif
      end
   end

   // NOTE: the array has no reset branch; a reset on every word would turn
   // a RAM into a flop bank. Known contents come from the clear sequencer.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM with registered ready, error and read-return path.
   // Service is gated on dmem_ready so that ready means exactly "accesses
   // presented this cycle are honoured".
   // ---------------------------------------------------------------------
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_INIT;
         dmem_ready <= 1'b0;
         dmem_err   <= 1'b0;
         drv_q      <= 1'b0;
         rdata_q    <= '0;
`ifdef DMEM_RESPONDER_CLEAR_EN
         clr_idx    <= '0;
`endif
      end else begin
         dmem_ready <= (state == ST_RUN);

         case (state)
`ifdef DMEM_RESPONDER_CLEAR_EN
            ST_INIT:  state <= ST_CLEAR;
            ST_CLEAR: begin
               clr_idx <= clr_idx + ADDR_W'(1);
               if (clr_idx == ADDR_W'(DEPTH - 1)) begin
                  state <= ST_RUN;
               end
            end
`else
            ST_INIT:  state <= ST_RUN;
`endif
            default:  state <= ST_RUN;   // RUN is held until rst
         endcase

         // Any rejected access, read or write, flags an error next cycle.
         dmem_err <= dmem_ready && !addr_ok;

         // Reads always return something: array data or zero when rejected.
         drv_q <= dmem_ready && !dmem_wen;
         if (dmem_ready && !dmem_wen) begin
            rdata_q <= addr_ok ? mem[idx] : 32'h0;
         end
      end
   end

   // The wen gate is combinational so a write issued right after a read
   // takes the bus back in the same cycle without contention.
   assign dmem_data = (drv_q && !dmem_wen) ? rdata_q : 'z;

endmodule
